// File: rtl/profiler_uart_reporter.sv
// Profiler snapshot reporter: sends a 34-byte frame (0xA5 header, eight 32-bit counters
// MSB byte first, XOR checksum of the payload) over an 8N1 UART transmitter.
module profiler_uart_reporter #(
  parameter int unsigned CLOCK_FREQ = 1000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [31:0] icache_hit_counter,
  input  logic [31:0] icache_miss_counter,
  input  logic [31:0] icache_request_counter,
  input  logic [31:0] dcache_hit_counter,
  input  logic [31:0] dcache_miss_counter,
  input  logic [31:0] dcache_request_counter,
  input  logic [31:0] icache_line_fill_latency_counter,
  input  logic [31:0] dcache_line_fill_latency_counter,
  output logic        uart_tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count
);

  localparam int unsigned ClksPerBit = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] BaudLast = CntW'(ClksPerBit - 1);
  localparam logic [5:0] LastByte = 6'd33;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StStartBit = 2'd1;
  localparam logic [1:0] StDataBits = 2'd2;
  localparam logic [1:0] StStopBit  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [5:0]      byte_idx_q, byte_idx_d;
  logic [255:0]    snapshot_q, snapshot_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic       bit_end;
  logic [7:0] checksum;
  logic [4:0] payload_sel;
  logic [7:0] cur_byte;

  assign bit_end = (baud_cnt_q == BaudLast);

  always_comb begin
    checksum = 8'h00;
    for (int i = 0; i < 32; i++) begin
      checksum = checksum ^ snapshot_q[8*i +: 8];
    end
  end

  // Byte 1 is the top byte of the snapshot, byte 32 the bottom one.
  assign payload_sel = 5'(6'd32 - byte_idx_q);

  always_comb begin
    if (byte_idx_q == 6'd0) begin
      cur_byte = 8'hA5;
    end else if (byte_idx_q == LastByte) begin
      cur_byte = checksum;
    end else begin
      cur_byte = snapshot_q[{payload_sel, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    byte_idx_d    = byte_idx_q;
    snapshot_d    = snapshot_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;

    if (!enable) begin
      // Abort also wins over a frame completing on this same edge.
      state_d    = StIdle;
      tx_d       = 1'b1;
      busy_d     = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      byte_idx_d = '0;
    end else begin
      if (state_q != StIdle) begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StStartBit;
            snapshot_d = {icache_hit_counter, icache_miss_counter, icache_request_counter,
                          dcache_hit_counter, dcache_miss_counter, dcache_request_counter,
                          icache_line_fill_latency_counter, dcache_line_fill_latency_counter};
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
          end
        end
        StStartBit: begin
          if (bit_end) begin
            state_d   = StDataBits;
            bit_cnt_d = '0;
            tx_d      = cur_byte[0];
          end
        end
        StDataBits: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = StStopBit;
              bit_cnt_d = '0;
              tx_d      = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = cur_byte[bit_cnt_q + 3'd1];
            end
          end
        end
        StStopBit: begin
          if (bit_end) begin
            if (byte_idx_q < LastByte) begin
              state_d    = StStartBit;
              byte_idx_d = byte_idx_q + 6'd1;
              tx_d       = 1'b0;
            end else begin
              state_d       = StIdle;
              byte_idx_d    = '0;
              busy_d        = 1'b0;
              done_d        = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      baud_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      byte_idx_q    <= '0;
      snapshot_q    <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_idx_q    <= byte_idx_d;
      snapshot_q    <= snapshot_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign uart_tx     = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_profiler_uart_reporter.sv
// Bench for profiler_uart_reporter: a frame-level model predicts uart_tx/busy/done/frame_count
// every cycle; directed cases plus randomized frames, aborts and mid-frame counter changes.
module tb_profiler_uart_reporter;

  localparam int Cpb       = 4;
  localparam int FrameCyc  = 340 * Cpb;
  localparam int ByteCyc   = 10 * Cpb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ctr [8];
  logic        uart_tx, busy, done;
  logic [15:0] frame_count;

  profiler_uart_reporter #(
    .CLOCK_FREQ (16),
    .BAUD_RATE  (4)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .enable                           (enable),
    .start                            (start),
    .icache_hit_counter               (ctr[0]),
    .icache_miss_counter              (ctr[1]),
    .icache_request_counter           (ctr[2]),
    .dcache_hit_counter               (ctr[3]),
    .dcache_miss_counter              (ctr[4]),
    .dcache_request_counter           (ctr[5]),
    .icache_line_fill_latency_counter (ctr[6]),
    .dcache_line_fill_latency_counter (ctr[7]),
    .uart_tx                          (uart_tx),
    .busy                             (busy),
    .done                             (done),
    .frame_count                      (frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: frame bytes fixed at accept, waveform derived from time offset.
  logic [7:0]  frame_bytes [34];
  bit          m_active = 0;
  int          m_t = 0;
  bit          m_done = 0;
  logic [15:0] m_fc = 16'h0000;

  function automatic void build_frame();
    logic [7:0] x;
    x = 8'h00;
    frame_bytes[0] = 8'hA5;
    for (int c = 0; c < 8; c++) begin
      for (int b = 0; b < 4; b++) begin
        frame_bytes[1 + c*4 + b] = ctr[c][31 - 8*b -: 8];
        x = x ^ ctr[c][31 - 8*b -: 8];
      end
    end
    frame_bytes[33] = x;
  endfunction

  function automatic logic exp_tx_at(input int t);
    int         bitno;
    int         pos;
    logic [7:0] by;
    bitno = t / Cpb;
    pos   = bitno % 10;
    by    = frame_bytes[bitno / 10];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos - 1];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0;
      m_done   = 0;
      m_fc     = 16'h0000;
      m_t      = 0;
    end else begin
      m_done = 0;
      if (!enable) begin
        m_active = 0;
      end else if (m_active) begin
        m_t++;
        if (m_t == FrameCyc) begin
          m_active = 0;
          m_done   = 1;
          m_fc     = m_fc + 16'd1;
        end
      end else if (start) begin
        m_active = 1;
        m_t      = 0;
        build_frame();
      end
    end
  end

  // Per-cycle compare, plus capture of DUT bit values and frame length.
  logic bits_seen [340];
  int   cyc = 0;
  int   fall_cyc = 0;
  int   last_len = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    check("tx", uart_tx, m_active ? exp_tx_at(m_t) : 1'b1);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("frame_count", frame_count, m_fc);
    if (m_active && (m_t % Cpb) == 1) bits_seen[m_t / Cpb] = uart_tx;
    if (busy && !prev_busy) fall_cyc = cyc;
    if (done) last_len = cyc - fall_cyc;
    prev_busy = busy;
  end

  function automatic logic [7:0] seen_byte(input int b);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = bits_seen[b*10 + 1 + j];
    return v;
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < FrameCyc + 20) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", done, 1'b1);
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (!(m_active && m_t >= target) && n < FrameCyc + 20) begin
      @(negedge clk);
      n++;
    end
    if (!(m_active && m_t >= target)) check("wait_timeout", 32'(m_t), 32'(target));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [9:0]  pat;
    logic [15:0] fc_hold;
    int          abort_at;
    int          n;

    for (int i = 0; i < 8; i++) ctr[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_fc", frame_count, 16'h0);

    // All-zero frame, accept on first edge after reset release.
    #2 rst = 1'b1;
    enable = 1'b1;
    pulse_start();
    check("first_accept_busy", busy, 1'b1);
    check("first_accept_tx", uart_tx, 1'b0);
    wait_done();
    @(negedge clk);
    check("zero_len", 32'(last_len), 32'd1360);
    check("zero_fc", frame_count, 16'd1);
    check("zero_hdr", seen_byte(0), 8'hA5);
    check("zero_b17", seen_byte(17), 8'h00);
    check("zero_csum", seen_byte(33), 8'h00);

    // Single counter pattern.
    ctr[0] = 32'h12345678;
    pulse_start();
    check("model_csum_08", frame_bytes[33], 8'h08);
    check("model_b2_34", frame_bytes[2], 8'h34);
    wait_done();
    @(negedge clk);
    for (int i = 0; i < 10; i++) pat[i] = bits_seen[i];
    check("hdr_bits", pat, 10'b11_0100_1010);
    check("b1", seen_byte(1), 8'h12);
    check("b2", seen_byte(2), 8'h34);
    check("b3", seen_byte(3), 8'h56);
    check("b4", seen_byte(4), 8'h78);
    check("csum08", seen_byte(33), 8'h08);

    // Counters change mid-frame; next frame picks them up.
    pulse_start();
    wait_t(5 * ByteCyc);
    for (int i = 0; i < 8; i++) ctr[i] = 32'hFFFF_FFFF;
    wait_done();
    @(negedge clk);
    check("snap_b1", seen_byte(1), 8'h12);
    check("snap_b8", seen_byte(8), 8'h00);
    pulse_start();
    wait_done();
    @(negedge clk);
    check("ff_b1", seen_byte(1), 8'hFF);
    check("ff_b32", seen_byte(32), 8'hFF);
    check("ff_csum", seen_byte(33), 8'h00);

    // Start while busy is ignored; held start gives back-to-back frames.
    pulse_start();
    wait_t(10 * ByteCyc);
    pulse_start();
    wait_done();
    fc_hold = frame_count;
    start = 1'b1;
    @(negedge clk);
    wait_done();
    @(negedge clk);
    check("b2b_tx_low", uart_tx, 1'b0);
    check("b2b_busy", busy, 1'b1);
    check("b2b_fc", frame_count, fc_hold + 16'd1);
    wait_done();
    start = 1'b0;
    @(negedge clk);
    check("b2b_fc2", frame_count, fc_hold + 16'd2);

    // Abort with enable at byte 20; start ignored while disabled.
    fc_hold = frame_count;
    pulse_start();
    wait_t(20 * ByteCyc);
    enable = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    check("abort_tx", uart_tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_fc", frame_count, fc_hold);
    check("dis_start_busy", busy, 1'b0);
    start  = 1'b0;
    enable = 1'b1;

    // Abort coinciding with the last stop bit ending.
    pulse_start();
    wait_t(FrameCyc - 1);
    enable = 1'b0;
    @(negedge clk);
    check("late_abort_done", done, 1'b0);
    check("late_abort_fc", frame_count, fc_hold);
    enable = 1'b1;

    // Asynchronous reset mid-frame, during a start bit.
    pulse_start();
    wait_t(3 * ByteCyc + 1);
    #2 rst = 1'b0;
    #1 check("async_rst_tx", uart_tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_fc", frame_count, 16'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    pulse_start();
    check("post_rst_busy", busy, 1'b1);
    wait_done();
    @(negedge clk);

    // frame_count wrap.
    #2;
    dut.frame_count_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    @(negedge clk);
    pulse_start();
    wait_done();
    check("wrap_fc", frame_count, 16'h0000);
    @(negedge clk);

    // Randomized frames with counter churn, stray starts and occasional aborts.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 8; i++) ctr[i] = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FrameCyc - 1)) : -1;
      n = 0;
      while (m_active && n < FrameCyc + 20) begin
        if ($urandom_range(0, 30) == 0) ctr[$urandom_range(0, 7)] = $urandom;
        start = ($urandom_range(0, 40) == 0);
        if (m_t == abort_at) enable = 1'b0;
        @(negedge clk);
        n++;
      end
      if (m_active) check("rand_timeout", 32'(m_active), 32'd0);
      start  = 1'b0;
      enable = 1'b1;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
